ysyx_23060203_idu_pipe: RTL

YSYX_23060203_IDU_PIPE -- requirements
Module: ysyx_23060203_idu_pipe

---
 rtl/ysyx_23060203_pkg.sv | 57 +++++
 rtl/ysyx_23060203_idu_pipe_if.sv | 32 +++
 rtl/ysyx_23060203_immgen.sv | 46 ++++
 rtl/ysyx_23060203_idu_pipe.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ysyx_23060203_pkg.sv
// Shared decode definitions for the ysyx_23060203 IDU: opcode constants,
// immediate-format encoding and the decode result record.
package ysyx_23060203_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] imm;
        fmt_e        fmt;
        logic        illegal;
    } dec_t;

    function automatic logic opcode_known(input logic [6:0] op);
        logic known;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_STORE,
            OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_OP: known = 1'b1;
            default:                                    known = 1'b0;
        endcase
        return known;
    endfunction

    // Returns {uses_rd, uses_rs1, uses_rs2} for a format.
    function automatic logic [2:0] reg_use(input fmt_e fmt);
        logic [2:0] use_bits;
        case (fmt)
            FMT_R:   use_bits = 3'b111;
            FMT_I:   use_bits = 3'b110;
            FMT_S:   use_bits = 3'b011;
            FMT_B:   use_bits = 3'b011;
            FMT_U:   use_bits = 3'b100;
            FMT_J:   use_bits = 3'b100;
            default: use_bits = 3'b000;
        endcase
        return use_bits;
    endfunction

endpackage

// File: rtl/ysyx_23060203_idu_pipe_if.sv
// IFU->IDU->EXU handshake and registered decode-result bundle.
interface ysyx_23060203_idu_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_src1;
    logic [XLEN-1:0] out_src2;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [31:0]     out_inst;
    logic            out_illegal;
    logic [2:0]      out_fmt;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_src1, out_src2, out_imm,
               out_rd, out_inst, out_illegal, out_fmt
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_src1, out_src2, out_imm,
               out_rd, out_inst, out_illegal, out_fmt
    );
endinterface

// File: rtl/ysyx_23060203_immgen.sv
// Combinational RV32I immediate generator; unknown opcodes report FMT_R with a zero immediate.
module ysyx_23060203_immgen
    import ysyx_23060203_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm,
    output fmt_e        fmt
);

    // Opcode-driven format select and immediate assembly
    always_comb begin
        imm = 32'd0;
        fmt = FMT_R;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                fmt = FMT_I;
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                fmt = FMT_B;
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                imm = {inst[31:12], 12'd0};
            end
            OP_JAL: begin
                fmt = FMT_J;
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_OP: begin
                fmt = FMT_R;
                imm = 32'd0;
            end
            default: begin
                fmt = FMT_R;
                imm = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060203_idu_pipe.sv
// Decode stage: immediate/format decode, operand fetch with writeback forwarding,
// and a single-entry valid/ready pipeline register toward the EXU.
module ysyx_23060203_idu_pipe
    import ysyx_23060203_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NR_REG = 16,
    parameter int RA_W   = $clog2(NR_REG)
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_23060203_idu_pipe_if.slave   io,
    output logic [RA_W-1:0]           rf_raddr1,
    output logic [RA_W-1:0]           rf_raddr2,
    input  logic [XLEN-1:0]           rf_rdata1,
    input  logic [XLEN-1:0]           rf_rdata2,
    input  logic                      wb_en,
    input  logic [RA_W-1:0]           wb_addr,
    input  logic [XLEN-1:0]           wb_data,
    input  logic                      flush
);

    localparam logic RV32E = (NR_REG == 16) ? 1'b1 : 1'b0;

    logic [31:0]     imm_s;
    fmt_e            fmt_s;
    logic [2:0]      use_s;
    logic            bad_reg_s;
    dec_t            dec_s;
    logic [XLEN-1:0] src1_s;
    logic [XLEN-1:0] src2_s;
    logic            fire_s;

    logic            valid_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] src1_r;
    logic [XLEN-1:0] src2_r;
    logic [XLEN-1:0] imm_r;
    logic [4:0]      rd_r;
    logic [31:0]     inst_r;
    logic            illegal_r;
    fmt_e            fmt_r;

    ysyx_23060203_immgen u_immgen (
        .inst (io.in_inst),
        .imm  (imm_s),
        .fmt  (fmt_s)
    );

    assign rf_raddr1   = io.in_inst[15 +: RA_W];
    assign rf_raddr2   = io.in_inst[20 +: RA_W];
    assign io.in_ready = !valid_r || io.out_ready;
    assign fire_s      = io.in_valid && io.in_ready;

    // Decode record; on RV32E any used register field with bit 4 set is illegal
    always_comb begin
        use_s       = reg_use(fmt_s);
        bad_reg_s   = RV32E && ((use_s[2] && io.in_inst[11]) ||
                                (use_s[1] && io.in_inst[19]) ||
                                (use_s[0] && io.in_inst[24]));
        dec_s.rd      = io.in_inst[11:7];
        dec_s.imm     = imm_s;
        dec_s.fmt     = fmt_s;
        dec_s.illegal = !opcode_known(io.in_inst[6:0]) || bad_reg_s;
    end

    // Operand 1: x0 reads zero, same-cycle writeback overrides the register file
    always_comb begin
        if (rf_raddr1 == {RA_W{1'b0}}) begin
            src1_s = {XLEN{1'b0}};
        end else if (wb_en && (wb_addr == rf_raddr1)) begin
            src1_s = wb_data;
        end else begin
            src1_s = rf_rdata1;
        end
    end

    // Operand 2: same forwarding rule as operand 1
    always_comb begin
        if (rf_raddr2 == {RA_W{1'b0}}) begin
            src2_s = {XLEN{1'b0}};
        end else if (wb_en && (wb_addr == rf_raddr2)) begin
            src2_s = wb_data;
        end else begin
            src2_s = rf_rdata2;
        end
    end

    // Pipeline register: flush beats an input fire; payload only moves on fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r   <= 1'b0;
            pc_r      <= {XLEN{1'b0}};
            src1_r    <= {XLEN{1'b0}};
            src2_r    <= {XLEN{1'b0}};
            imm_r     <= {XLEN{1'b0}};
            rd_r      <= 5'd0;
            inst_r    <= 32'd0;
            illegal_r <= 1'b0;
            fmt_r     <= FMT_R;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (fire_s) begin
            valid_r   <= 1'b1;
            pc_r      <= io.in_pc;
            src1_r    <= src1_s;
            src2_r    <= src2_s;
            imm_r     <= XLEN'($signed(dec_s.imm));
            rd_r      <= dec_s.rd;
            inst_r    <= io.in_inst;
            illegal_r <= dec_s.illegal;
            fmt_r     <= dec_s.fmt;
        end else if (io.out_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign io.out_valid   = valid_r;
    assign io.out_pc      = pc_r;
    assign io.out_src1    = src1_r;
    assign io.out_src2    = src2_r;
    assign io.out_imm     = imm_r;
    assign io.out_rd      = rd_r;
    assign io.out_inst    = inst_r;
    assign io.out_illegal = illegal_r;
    assign io.out_fmt     = fmt_r;

endmodule
